key_matrix_scan: RTL and testbench
==================================

Name: key_matrix_scan

Overview:
- Parametrised successor to the fixed 4x4 keypad scanner, feeding the calculator compute path.
- Drives an ROWS x COLS matrix with one-cold column scanning and debounces whole scan frames.
- Rejects multi-key (ghost) frames and supports optional auto-repeat.
- Queues key codes in a show-ahead FIFO with a valid/ready pop handshake.

Parameters:
- ROWS, 4, number of row inputs (>=1)
- COLS, 4, number of column outputs (>=2)
- SCAN_DIV, 2, clk cycles each column is driven (>=2)
- DEBOUNCE_FRAMES, 3, consecutive frames needed to accept a press or a release (>=1)
- FIFO_DEPTH, 4, key-code FIFO entries (power of 2, >=2)
- REPEAT_DLY, 8, frames held before the first auto-repeat
- REPEAT_RATE, 4, frames between later auto-repeats
- Derived localparam CODE_W = clog2(ROWS*COLS), minimum 1.

Ports:
- clk  in  1  block clock (1 kHz scan clock in the current design)
- rst_n  in  1  asynchronous active-low reset
- row  in  ROWS  matrix rows, active-low (externally pulled up)
- col  out  COLS  column drive, one-cold (active-low)
- repeat_en  in  1  enables auto-repeat while a key is held
- key_ready  in  1  consumer accepts key_code this cycle
- ovf_clr  in  1  clears overflow
- key_valid  out  1  FIFO not empty
- key_code  out  CODE_W  FIFO head; code = r*COLS + c
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky; a push was dropped
- multi_key  out  1  last completed frame had >=2 keys pressed

Behaviour:
- Reset (async, all registers): col = all ones except col[0]=0; key_valid=0; key_code=0; fifo_full=0; overflow=0; multi_key=0. FSM goes to IDLE, all counters 0, FIFO empty.
- Scan: a divider counts 0..SCAN_DIV-1. col advances to the next column (c -> c+1, wrapping COLS-1 -> 0) on the cycle after the count reaches SCAN_DIV-1.
- Row sampling: row is sampled only on the count = SCAN_DIV-1 cycle, giving settle time. row[r]=0 while col[c]=0 marks key (r,c) pressed in the frame bitmap.
- Frame end: the sample of column COLS-1 completes a frame (COLS*SCAN_DIV clocks). Frame result is evaluated on that cycle:
  - no key pressed: NONE
  - exactly one key: SINGLE(code)
  - two or more: MULTI; multi_key is set to 1 for that frame and to 0 otherwise, updated at each frame end.
- FSM (advances on frame end only):
  - IDLE: SINGLE(k) -> latch k, cnt=1, go to DEBOUNCE. If DEBOUNCE_FRAMES=1, push k and go straight to HELD.
  - DEBOUNCE: SINGLE(latched) -> cnt++; when cnt reaches DEBOUNCE_FRAMES, push the code and go to HELD with rep=0. Any other result -> IDLE, no push.
  - HELD: SINGLE(latched) -> rep++ if repeat_en, otherwise rep is held at 0. Push when rep = REPEAT_DLY, then each further REPEAT_RATE frames. Any other result -> RELEASE with cnt=1.
  - RELEASE: SINGLE(latched) -> back to HELD, no push, rep preserved. Any other result -> cnt++; at DEBOUNCE_FRAMES go to IDLE. A new key is therefore only accepted after a full debounced release.
- FIFO (show-ahead):
  - key_code always shows the head entry; key_valid = !empty.
  - Pop when key_valid && key_ready. The new head appears on the next cycle.
  - Push while full and no pop in the same cycle: the new code is dropped, FIFO is unchanged, overflow is set.
  - Push and pop in the same cycle: both execute, occupancy is unchanged, no overflow, including when full.
  - Pop while empty is ignored.
  - overflow clears only on ovf_clr=1 or reset. If a set and ovf_clr occur in the same cycle, set wins.
- Latency: a push lands on the frame-end cycle; key_valid/key_code update on the next clk edge. A stable press is queued DEBOUNCE_FRAMES frames after the first frame that sees it.
- repeat_en is sampled each frame end. Deasserting it in HELD zeroes rep.

Test Plan:
- All tests use defaults (frame = 8 clk).
- Reset release -> col=4'b1110; after 2 clk col=4'b1101; after 8 clk col=4'b1110; key_valid=0, overflow=0.
- Hold r2c1 steady for 3 frames (row[2]=0 whenever col[1]=0) -> exactly one push, key_code=9, key_valid=1. Continue holding 20 frames with repeat_en=0 -> no further pushes. key_ready=1 for one cycle -> key_valid=0.
- Bounce r0c3: present 2 frames, absent 1, present 2, absent 5 -> FIFO stays empty.
- Press r0c0 and r1c3 together for 6 frames -> multi_key=1 at each frame end, no push. Release -> multi_key=0 after the next frame.
- repeat_en=1, key_ready=0, hold r1c1 for 19 frames -> pushes at frames 3, 11, 15, 19; FIFO = 5,5,5,5 and fifo_full=1. Frame 23 -> overflow=1, contents unchanged. Pop and push coinciding when full -> occupancy stays 4, no overflow. ovf_clr -> overflow=0.
- Assert rst_n low mid-DEBOUNCE with 2 FIFO entries -> immediate reset values, FIFO empty. The held key needs 3 fresh frames to be queued.

Source files
------------

// File: rtl/key_matrix_scan.sv
// Row/column keypad scanner with frame debounce, ghost rejection,
// auto-repeat and a show-ahead key-code FIFO.
module key_matrix_scan #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 2,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DLY      = 8,
  parameter int REPEAT_RATE     = 4,
  localparam int CODE_W =
    (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  input  logic              repeat_en,
  input  logic              key_ready,
  input  logic              ovf_clr,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              fifo_full,
  output logic              overflow,
  output logic              multi_key
);

  localparam int NKEY  = ROWS * COLS;
  localparam int DIV_W =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W = $clog2(COLS);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int REP_W =
    $clog2(REPEAT_DLY + REPEAT_RATE + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB,
    S_HELD,
    S_REL
  } state_t;

  logic [DIV_W-1:0]  div_q;
  logic [COL_W-1:0]  col_idx;
  logic [NKEY-1:0]   map_q;
  logic [NKEY-1:0]   map_now;
  logic              sample;
  logic              frame_end;
  logic [1:0]        hits;
  logic [CODE_W-1:0] one_code;
  logic              single;
  logic              match;

  state_t            state_q, state_n;
  logic [CODE_W-1:0] key_q, key_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [REP_W-1:0]  rep_q, rep_n;
  logic              push;

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              empty, full, pop;
  logic              do_push, drop;

  assign sample    = div_q == DIV_W'(SCAN_DIV - 1);
  assign frame_end = sample &&
                     col_idx == COL_W'(COLS - 1);

  always_comb begin
    col = '1;
    for (int c = 0; c < COLS; c++)
      if (col_idx == COL_W'(c)) col[c] = 1'b0;
  end

  // Merge the current column's rows into the frame bitmap.
  always_comb begin
    map_now = map_q;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (sample && col_idx == COL_W'(c))
          map_now[r*COLS + c] = ~row[r];
  end

  always_comb begin
    hits     = 2'd0;
    one_code = '0;
    for (int i = 0; i < NKEY; i++) begin
      if (map_now[i]) begin
        if (hits == 2'd0) one_code = CODE_W'(i);
        if (hits != 2'd2) hits = hits + 2'd1;
      end
    end
  end

  assign single = hits == 2'd1;
  assign match  = single && one_code == key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      col_idx   <= '0;
      map_q     <= '0;
      multi_key <= 1'b0;
    end else begin
      if (sample) begin
        div_q   <= '0;
        col_idx <= (col_idx == COL_W'(COLS - 1)) ?
                   '0 : col_idx + 1'b1;
        map_q   <= frame_end ? '0 : map_now;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (frame_end) multi_key <= hits == 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_n;
      key_q   <= key_n;
      cnt_q   <= cnt_n;
      rep_q   <= rep_n;
    end
  end

  always_comb begin
    state_n = state_q;
    key_n   = key_q;
    cnt_n   = cnt_q;
    rep_n   = rep_q;
    push    = 1'b0;
    if (frame_end) begin
      case (state_q)
        S_IDLE: begin
          if (single) begin
            key_n = one_code;
            cnt_n = CNT_W'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              push    = 1'b1;
              rep_n   = '0;
              state_n = S_HELD;
            end else begin
              state_n = S_DEB;
            end
          end
        end
        S_DEB: begin
          if (match) begin
            cnt_n = cnt_q + 1'b1;
            if (cnt_q + 1'b1 ==
                CNT_W'(DEBOUNCE_FRAMES)) begin
              push    = 1'b1;
              rep_n   = '0;
              state_n = S_HELD;
            end
          end else begin
            state_n = S_IDLE;
          end
        end
        S_HELD: begin
          if (match) begin
            if (!repeat_en) begin
              rep_n = '0;
            end else begin
              rep_n = rep_q + 1'b1;
              if (rep_q + 1'b1 == REP_W'(REPEAT_DLY))
                push = 1'b1;
              // Fold back so the repeat period needs no divider.
              if (rep_q + 1'b1 ==
                  REP_W'(REPEAT_DLY + REPEAT_RATE)) begin
                push  = 1'b1;
                rep_n = REP_W'(REPEAT_DLY);
              end
            end
          end else if (DEBOUNCE_FRAMES == 1) begin
            state_n = S_IDLE;
          end else begin
            cnt_n   = CNT_W'(1);
            state_n = S_REL;
          end
        end
        S_REL: begin
          if (match) begin
            state_n = S_HELD;
          end else begin
            cnt_n = cnt_q + 1'b1;
            if (cnt_q + 1'b1 ==
                CNT_W'(DEBOUNCE_FRAMES))
              state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop     = !empty && key_ready;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign key_valid = !empty;
  assign fifo_full = full;
  assign key_code  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PTR_W-1:0]] <= one_code;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: frame-level key model plus queue,
// checked every cycle, with directed literal checkpoints.
module tb_key_matrix_scan;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SDIV = 2;
  localparam int DF   = 3;
  localparam int FD   = 4;
  localparam int DLY  = 8;
  localparam int RATE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic       repeat_en;
  logic       key_ready;
  logic       ovf_clr;
  logic       key_valid;
  logic [3:0] key_code;
  logic       fifo_full;
  logic       overflow;
  logic       multi_key;

  bit pressed [ROWS][COLS];

  int checks = 0;
  int errors = 0;

  key_matrix_scan dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .repeat_en (repeat_en),
    .key_ready (key_ready),
    .ovf_clr   (ovf_clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .multi_key (multi_key)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low
  // while its column is driven low.
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r][c] && !col[c]) row[r] = 1'b0;
  end

  function automatic void check(string nm, int act,
                                int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endfunction

  int   cyc;
  bit   fb [ROWS*COLS];
  int   q [$];
  bit   m_ovf, m_multi, m_push, m_pop, m_drop;
  bit   acc;
  int   cand, run, hold, gap;
  int   nk, kk, cidx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      foreach (fb[i]) fb[i] = 1'b0;
      q.delete();
      m_ovf = 0; m_multi = 0;
      acc = 0; cand = 0; run = 0; hold = 0; gap = 0;
    end else begin
      m_push = 0;
      m_pop  = q.size() != 0 && key_ready;
      if (cyc % SDIV == SDIV - 1) begin
        cidx = (cyc / SDIV) % COLS;
        for (int r = 0; r < ROWS; r++)
          if (pressed[r][cidx]) fb[r*COLS + cidx] = 1'b1;
        if (cidx == COLS - 1) begin
          nk = 0; kk = 0;
          foreach (fb[i])
            if (fb[i]) begin nk++; kk = i; end
          m_multi = nk >= 2;
          if (!acc) begin
            if (nk == 1 && (run == 0 || kk == cand)) begin
              cand = kk;
              run++;
              if (run == DF) begin
                m_push = 1; acc = 1; hold = 0; gap = 0;
              end
            end else begin
              run = 0;
            end
          end else if (nk == 1 && kk == cand) begin
            if (gap > 0) begin
              gap = 0;
            end else begin
              hold = repeat_en ? hold + 1 : 0;
              if (hold == DLY ||
                  (hold > DLY && (hold - DLY) % RATE == 0))
                m_push = 1;
            end
          end else begin
            gap++;
            if (gap == DF) begin acc = 0; run = 0; end
          end
          foreach (fb[i]) fb[i] = 1'b0;
        end
      end
      m_drop = m_push && q.size() == FD && !m_pop;
      if (m_pop) void'(q.pop_front());
      if (m_push && !m_drop) q.push_back(cand);
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      cyc++;
    end
  end

  logic [3:0] exp_col;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_col = 4'hF;
      exp_col[(cyc / SDIV) % COLS] = 1'b0;
      check("m_col", col, exp_col);
      check("m_valid", key_valid, q.size() != 0);
      if (q.size() != 0) check("m_code", key_code, q[0]);
      check("m_full", fifo_full, q.size() == FD);
      check("m_ovf", overflow, m_ovf);
      check("m_multi", multi_key, m_multi);
    end
  end

  task automatic nf(input int n);
    repeat (n * COLS * SDIV) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat_en = 1'b0;
    key_ready = 1'b0;
    ovf_clr = 1'b0;
    foreach (pressed[r, c]) pressed[r][c] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_col", col, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    check("col_step", col, 4'b1101);
    repeat (6) @(negedge clk);
    check("col_wrap", col, 4'b1110);

    pressed[2][1] = 1'b1;
    nf(3);
    check("r2c1_valid", key_valid, 1);
    check("r2c1_code", key_code, 9);
    nf(20);
    check("norep_valid", key_valid, 1);
    check("norep_full", fifo_full, 0);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("pop_empty", key_valid, 0);
    repeat (7) @(negedge clk);
    pressed[2][1] = 1'b0;
    nf(4);

    pressed[0][3] = 1'b1; nf(2);
    pressed[0][3] = 1'b0; nf(1);
    pressed[0][3] = 1'b1; nf(2);
    pressed[0][3] = 1'b0; nf(5);
    check("bounce_empty", key_valid, 0);

    pressed[0][0] = 1'b1;
    pressed[1][3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nf(1);
      check("ghost_multi", multi_key, 1);
    end
    check("ghost_nopush", key_valid, 0);
    pressed[0][0] = 1'b0;
    pressed[1][3] = 1'b0;
    nf(1);
    check("ghost_clear", multi_key, 0);
    nf(3);

    repeat_en = 1'b1;
    pressed[1][1] = 1'b1;
    nf(3);
    check("rep_first", key_code, 5);
    nf(16);
    check("rep_full", fifo_full, 1);
    check("rep_code", key_code, 5);
    check("rep_noovf", overflow, 0);
    nf(4);
    check("rep_ovf", overflow, 1);
    check("rep_still_full", fifo_full, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    repeat (7) @(negedge clk);
    nf(2);
    repeat (7) @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("pushpop_full", fifo_full, 1);
    check("pushpop_noovf", overflow, 0);
    nf(3);
    repeat (7) @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("set_wins", overflow, 1);

    repeat_en = 1'b0;
    key_ready = 1'b1;
    repeat (2) @(negedge clk);
    key_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("two_left_full", fifo_full, 0);
    check("two_left_valid", key_valid, 1);
    pressed[1][1] = 1'b0;
    nf(3);
    pressed[3][2] = 1'b1;
    nf(2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", key_valid, 0);
    check("arst_full", fifo_full, 0);
    check("arst_ovf", overflow, 0);
    check("arst_multi", multi_key, 0);
    check("arst_col", col, 4'b1110);
    check("arst_code", key_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nf(2);
    check("fresh_wait", key_valid, 0);
    nf(1);
    check("fresh_valid", key_valid, 1);
    check("fresh_code", key_code, 14);
    nf(1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
